mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/riscv_mem_pkg.sv | 80 ++++++++
 rtl/load_align_ext.sv | 40 ++++
 rtl/mem_access_unit.sv | 167 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the MEM stage: funct3 access codes, the access FSM
// encoding, the bubble values written to the WB side, and store lane helpers.
package riscv_mem_pkg;

    // Load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store funct3 encodings
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Access FSM: IDLE accepts a new op, BUSY waits for the bus to answer
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mem_state_e;

    // Bubble values loaded into the WB side while nothing retires
    localparam logic       NOP_REG_WRITE  = 1'b0;
    localparam logic [4:0] NOP_RD_ADDR    = 5'd0;
    localparam logic [1:0] NOP_MEM_TO_REG = 2'b00;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } acc_size_e;

    // Access width comes from funct3[1:0]; the reserved codes fall to word.
    function automatic acc_size_e access_size(input logic [2:0] funct3);
        acc_size_e sz;
        case (funct3[1:0])
            F3_SB[1:0]: sz = SZ_BYTE;
            F3_SH[1:0]: sz = SZ_HALF;
            F3_SW[1:0]: sz = SZ_WORD;
            default:    sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] addr_lo);
        logic mis;
        case (access_size(funct3))
            SZ_HALF: mis = addr_lo[0];
            SZ_WORD: mis = |addr_lo;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] funct3,
                                            input logic [1:0] addr_lo);
        logic [3:0] be;
        case (access_size(funct3))
            SZ_BYTE: be = 4'b0001 << addr_lo;
            SZ_HALF: be = 4'b0011 << addr_lo;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Data is replicated so every enabled lane already carries the value.
    function automatic logic [31:0] store_wdata(input logic [2:0]  funct3,
                                                input logic [31:0] rs2);
        logic [31:0] wd;
        case (access_size(funct3))
            SZ_BYTE: wd = {4{rs2[7:0]}};
            SZ_HALF: wd = {2{rs2[15:0]}};
            default: wd = rs2;
        endcase
        return wd;
    endfunction

endpackage

// File: rtl/load_align_ext.sv
// Picks the addressed lane out of the returned bus word and sign/zero extends
// it according to the load funct3.
module load_align_ext
    import riscv_mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] load_data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Lane selection by byte offset within the word
    always_comb begin
        byte_lane = rdata[7:0];
        case (addr_lo)
            2'd0:    byte_lane = rdata[7:0];
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            default: byte_lane = rdata[31:24];
        endcase
        half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    // Extension by load type; reserved codes return the whole word
    always_comb begin
        load_data = rdata;
        case (funct3)
            F3_LB:   load_data = {{24{byte_lane[7]}}, byte_lane};
            F3_LH:   load_data = {{16{half_lane[15]}}, half_lane};
            F3_LBU:  load_data = {24'd0, byte_lane};
            F3_LHU:  load_data = {16'd0, half_lane};
            F3_LW:   load_data = rdata;
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage of the pipeline: drives the data-memory bus for loads/stores,
// stalls upstream while an access is outstanding, and registers the
// instruction into the WB side once it completes.
//
// Bus handshake: an access is presented by raising dmem_req_o with we/addr/be/
// wdata; all of them stay constant until dmem_ready_i is sampled high on a
// rising edge, which completes the access (read data is taken from
// dmem_rdata_i in that same cycle). Ready seen without a request is ignored.
module mem_access_unit
    import riscv_mem_pkg::*;
#(
    parameter int XLEN = 32  // only 32 is supported
) (
    input  logic            clk,
    input  logic            rst,

    input  logic [XLEN-1:0] mem_alu_result_i,
    input  logic [XLEN-1:0] mem_rs2_data_i,
    input  logic [4:0]      mem_rd_addr_i,
    input  logic [XLEN-1:0] mem_pc_plus_4_i,
    input  logic [2:0]      mem_funct3_i,
    input  logic            mem_mem_read_i,
    input  logic            mem_mem_write_i,
    input  logic            mem_reg_write_i,
    input  logic [1:0]      mem_mem_to_reg_i,

    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [3:0]      dmem_be_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    input  logic            dmem_ready_i,
    input  logic [XLEN-1:0] dmem_rdata_i,

    output logic            mem_stall_o,

    output logic [XLEN-1:0] wb_alu_result_o,
    output logic [XLEN-1:0] wb_mem_rdata_o,
    output logic [4:0]      wb_rd_addr_o,
    output logic [XLEN-1:0] wb_pc_plus_4_o,
    output logic            wb_reg_write_o,
    output logic [1:0]      wb_mem_to_reg_o,
    output logic            wb_misaligned_o,

    output logic            dbg_state   // 1 while an access is outstanding
);

    mem_state_e      state;
    logic            mem_op;
    logic            misaligned;
    logic            start_access;

    // Snapshot of the instruction that owns the outstanding access
    logic [1:0]      acc_addr_lo;
    logic [2:0]      acc_funct3;
    logic            acc_is_write;
    logic [XLEN-1:0] acc_alu_result;
    logic [4:0]      acc_rd_addr;
    logic [XLEN-1:0] acc_pc_plus_4;
    logic            acc_reg_write;
    logic [1:0]      acc_mem_to_reg;

    logic [31:0]     load_data;

    assign mem_op       = mem_mem_read_i | mem_mem_write_i;
    assign misaligned   = mem_op & is_misaligned(mem_funct3_i, mem_alu_result_i[1:0]);
    assign start_access = mem_op & ~misaligned;

    // Stall is released in the cycle ready arrives so the pipeline advances
    // on the same edge that retires the access.
    assign mem_stall_o = ~rst & (((state == ST_IDLE) & start_access) |
                                 ((state == ST_BUSY) & ~dmem_ready_i));

    assign dbg_state = (state == ST_BUSY);

    load_align_ext u_load_align_ext (
        .rdata     (dmem_rdata_i),
        .addr_lo   (acc_addr_lo),
        .funct3    (acc_funct3),
        .load_data (load_data)
    );

    // Access FSM with registered bus and WB-side outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_IDLE;
            dmem_req_o      <= 1'b0;
            dmem_we_o       <= 1'b0;
            dmem_addr_o     <= '0;
            dmem_be_o       <= 4'b0000;
            dmem_wdata_o    <= '0;
            acc_addr_lo     <= 2'd0;
            acc_funct3      <= 3'd0;
            acc_is_write    <= 1'b0;
            acc_alu_result  <= '0;
            acc_rd_addr     <= 5'd0;
            acc_pc_plus_4   <= '0;
            acc_reg_write   <= 1'b0;
            acc_mem_to_reg  <= 2'b00;
            wb_alu_result_o <= '0;
            wb_mem_rdata_o  <= '0;
            wb_rd_addr_o    <= 5'd0;
            wb_pc_plus_4_o  <= '0;
            wb_reg_write_o  <= 1'b0;
            wb_mem_to_reg_o <= 2'b00;
            wb_misaligned_o <= 1'b0;
        end else begin
            // Bubble unless an instruction retires this edge
            wb_alu_result_o <= '0;
            wb_mem_rdata_o  <= '0;
            wb_rd_addr_o    <= NOP_RD_ADDR;
            wb_pc_plus_4_o  <= '0;
            wb_reg_write_o  <= NOP_REG_WRITE;
            wb_mem_to_reg_o <= NOP_MEM_TO_REG;
            wb_misaligned_o <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (start_access) begin
                        state          <= ST_BUSY;
                        dmem_req_o     <= 1'b1;
                        dmem_we_o      <= mem_mem_write_i;
                        dmem_addr_o    <= {mem_alu_result_i[XLEN-1:2], 2'b00};
                        dmem_be_o      <= mem_mem_write_i
                                          ? store_be(mem_funct3_i, mem_alu_result_i[1:0])
                                          : 4'b1111;
                        dmem_wdata_o   <= mem_mem_write_i
                                          ? store_wdata(mem_funct3_i, mem_rs2_data_i)
                                          : '0;
                        acc_addr_lo    <= mem_alu_result_i[1:0];
                        acc_funct3     <= mem_funct3_i;
                        acc_is_write   <= mem_mem_write_i;
                        acc_alu_result <= mem_alu_result_i;
                        acc_rd_addr    <= mem_rd_addr_i;
                        acc_pc_plus_4  <= mem_pc_plus_4_i;
                        acc_reg_write  <= mem_reg_write_i;
                        acc_mem_to_reg <= mem_mem_to_reg_i;
                    end else if (mem_op) begin
                        // Misaligned: no bus traffic, only the flag retires
                        wb_misaligned_o <= 1'b1;
                    end else begin
                        wb_alu_result_o <= mem_alu_result_i;
                        wb_rd_addr_o    <= mem_rd_addr_i;
                        wb_pc_plus_4_o  <= mem_pc_plus_4_i;
                        wb_reg_write_o  <= mem_reg_write_i;
                        wb_mem_to_reg_o <= mem_mem_to_reg_i;
                    end
                end
                ST_BUSY: begin
                    if (dmem_ready_i) begin
                        state           <= ST_IDLE;
                        dmem_req_o      <= 1'b0;
                        dmem_we_o       <= 1'b0;
                        wb_alu_result_o <= acc_alu_result;
                        wb_mem_rdata_o  <= acc_is_write ? '0 : load_data;
                        wb_rd_addr_o    <= acc_rd_addr;
                        wb_pc_plus_4_o  <= acc_pc_plus_4;
                        wb_reg_write_o  <= acc_reg_write;
                        wb_mem_to_reg_o <= acc_mem_to_reg;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit. Each operation is turned into a
// cycle-by-cycle list of expected outputs derived from the access rules
// (latency, stall, bubble, lane/extension arithmetic); a compare process
// checks the DUT against that list on every falling edge.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_alu_result_i, mem_rs2_data_i, mem_pc_plus_4_i;
    logic [4:0]  mem_rd_addr_i;
    logic [2:0]  mem_funct3_i;
    logic        mem_mem_read_i, mem_mem_write_i, mem_reg_write_i;
    logic [1:0]  mem_mem_to_reg_i;
    logic        dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic        dmem_ready_i;
    logic [31:0] dmem_rdata_i;
    logic        mem_stall_o;
    logic [31:0] wb_alu_result_o, wb_mem_rdata_o, wb_pc_plus_4_o;
    logic [4:0]  wb_rd_addr_o;
    logic        wb_reg_write_o, wb_misaligned_o;
    logic [1:0]  wb_mem_to_reg_o;
    logic        dbg_state;

    mem_access_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .mem_alu_result_i(mem_alu_result_i), .mem_rs2_data_i(mem_rs2_data_i),
        .mem_rd_addr_i(mem_rd_addr_i), .mem_pc_plus_4_i(mem_pc_plus_4_i),
        .mem_funct3_i(mem_funct3_i), .mem_mem_read_i(mem_mem_read_i),
        .mem_mem_write_i(mem_mem_write_i), .mem_reg_write_i(mem_reg_write_i),
        .mem_mem_to_reg_i(mem_mem_to_reg_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_ready_i(dmem_ready_i), .dmem_rdata_i(dmem_rdata_i),
        .mem_stall_o(mem_stall_o),
        .wb_alu_result_o(wb_alu_result_o), .wb_mem_rdata_o(wb_mem_rdata_o),
        .wb_rd_addr_o(wb_rd_addr_o), .wb_pc_plus_4_o(wb_pc_plus_4_o),
        .wb_reg_write_o(wb_reg_write_o), .wb_mem_to_reg_o(wb_mem_to_reg_o),
        .wb_misaligned_o(wb_misaligned_o),
        .dbg_state(dbg_state)
    );

    // Clock / reset timing: period 10, rising edges at 5, 15, ...
    always #5 clk = ~clk;

    typedef struct packed {
        logic        stall;
        logic        busy;
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        rw;
        logic [4:0]  rd;
        logic [1:0]  m2r;
        logic        mis;
        logic        chk_data;   // wb holds a retired instruction
        logic        chk_rdata;  // ... and it was a load
        logic [31:0] alu;
        logic [31:0] pc4;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur, nxt, rec, cmp_e;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Bytes moved by an access of this funct3
    function automatic int size_bytes(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] lo,
                                               input logic [31:0] w);
        logic [31:0] s;
        s = w >> (8 * int'(lo));
        case (f3)
            3'b000:  return {{24{s[7]}}, s[7:0]};
            3'b001:  return {{16{s[15]}}, s[15:0]};
            3'b100:  return s & 32'h0000_00FF;
            3'b101:  return s & 32'h0000_FFFF;
            default: return w;
        endcase
    endfunction

    // Scoreboard: one expected record per cycle, checked on the falling edge
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cmp_e = exp_q.pop_front();
            chk("stall", {31'd0, mem_stall_o}, {31'd0, cmp_e.stall});
            chk("busy", {31'd0, dbg_state}, {31'd0, cmp_e.busy});
            chk("req", {31'd0, dmem_req_o}, {31'd0, cmp_e.req});
            if (cmp_e.req) begin
                chk("we", {31'd0, dmem_we_o}, {31'd0, cmp_e.we});
                chk("addr", dmem_addr_o, cmp_e.addr);
                chk("be", {28'd0, dmem_be_o}, {28'd0, cmp_e.be});
                if (cmp_e.we) chk("wdata", dmem_wdata_o, cmp_e.wdata);
            end
            chk("wb_rw", {31'd0, wb_reg_write_o}, {31'd0, cmp_e.rw});
            chk("wb_rd", {27'd0, wb_rd_addr_o}, {27'd0, cmp_e.rd});
            chk("wb_m2r", {30'd0, wb_mem_to_reg_o}, {30'd0, cmp_e.m2r});
            chk("wb_mis", {31'd0, wb_misaligned_o}, {31'd0, cmp_e.mis});
            if (cmp_e.chk_data) begin
                chk("wb_alu", wb_alu_result_o, cmp_e.alu);
                chk("wb_pc4", wb_pc_plus_4_o, cmp_e.pc4);
            end
            if (cmp_e.chk_rdata) chk("wb_rdata", wb_mem_rdata_o, cmp_e.rdata);
        end
    end

    function automatic exp_t bubble(input exp_t base);
        exp_t b;
        b = base;
        b.rw = 1'b0; b.rd = 5'd0; b.m2r = 2'b00; b.mis = 1'b0;
        b.chk_data = 1'b0; b.chk_rdata = 1'b0;
        return b;
    endfunction

    // Driver: presents one EX/MEM instruction (called just after a rising
    // edge) and plays the memory side, answering after wait_n BUSY cycles.
    task automatic run_op(input logic [2:0] f3, input logic rd_en, input logic wr_en,
                          input logic [31:0] alu, input logic [31:0] rs2,
                          input logic [4:0] rd, input logic [31:0] pc4,
                          input logic rw, input logic [1:0] m2r,
                          input int wait_n, input logic [31:0] rdata,
                          input logic idle_ready,
                          output int stall_cnt, output int req_cnt,
                          output logic [31:0] bus_addr, output logic [3:0] bus_be,
                          output logic [31:0] bus_wdata);
        int   nb;
        int   be_i;
        logic mem, mis;
        nb   = size_bytes(f3);
        mem  = rd_en | wr_en;
        mis  = mem && ((int'(alu[1:0]) % nb) != 0);
        stall_cnt = 0; req_cnt = 0; bus_addr = '0; bus_be = '0; bus_wdata = '0;

        mem_alu_result_i = alu; mem_rs2_data_i = rs2; mem_rd_addr_i = rd;
        mem_pc_plus_4_i = pc4; mem_funct3_i = f3; mem_mem_read_i = rd_en;
        mem_mem_write_i = wr_en; mem_reg_write_i = rw; mem_mem_to_reg_i = m2r;
        dmem_ready_i = idle_ready; dmem_rdata_i = $urandom;

        rec = cur; rec.stall = mem && !mis; exp_q.push_back(rec);
        #3;
        if (mem_stall_o) stall_cnt++;
        if (dmem_req_o) req_cnt++;
        nxt = bubble(cur);
        if (!mem) begin
            nxt.rw = rw; nxt.rd = rd; nxt.m2r = m2r; nxt.alu = alu; nxt.pc4 = pc4;
            nxt.chk_data = 1'b1;
        end else if (mis) begin
            nxt.mis = 1'b1;
        end else begin
            be_i = wr_en ? (((1 << nb) - 1) << int'(alu[1:0])) : 15;
            nxt.busy = 1'b1; nxt.req = 1'b1; nxt.we = wr_en;
            nxt.addr = alu & 32'hFFFF_FFFC;
            nxt.be = be_i[3:0];
            nxt.wdata = (nb == 1) ? rs2[7:0] * 32'h0101_0101 :
                        (nb == 2) ? rs2[15:0] * 32'h0001_0001 : rs2;
        end
        @(posedge clk); #1; cur = nxt;

        if (mem && !mis) begin
            for (int i = 0; i <= wait_n; i++) begin
                dmem_ready_i = (i == wait_n);
                dmem_rdata_i = (i == wait_n) ? rdata : $urandom;
                if (i == 0) begin
                    bus_addr = dmem_addr_o; bus_be = dmem_be_o; bus_wdata = dmem_wdata_o;
                end
                rec = cur; rec.stall = !dmem_ready_i; exp_q.push_back(rec);
                #3;
                if (mem_stall_o) stall_cnt++;
                if (dmem_req_o) req_cnt++;
                nxt = bubble(cur);
                if (i == wait_n) begin
                    nxt.busy = 1'b0; nxt.req = 1'b0;
                    nxt.rw = rw; nxt.rd = rd; nxt.m2r = m2r; nxt.alu = alu; nxt.pc4 = pc4;
                    nxt.chk_data = 1'b1;
                    nxt.chk_rdata = !wr_en;
                    nxt.rdata = model_load(f3, alu[1:0], rdata);
                end
                @(posedge clk); #1; cur = nxt;
            end
        end
        dmem_ready_i = 1'b0;
    endtask

    int          sc, rc;
    logic [31:0] ba, bw;
    logic [3:0]  bb;

    initial begin
        rst = 1'b1;
        mem_alu_result_i = '0; mem_rs2_data_i = '0; mem_rd_addr_i = '0;
        mem_pc_plus_4_i = '0; mem_funct3_i = '0; mem_mem_read_i = 1'b0;
        mem_mem_write_i = 1'b0; mem_reg_write_i = 1'b0; mem_mem_to_reg_i = '0;
        dmem_ready_i = 1'b0; dmem_rdata_i = '0;
        cur = '0;

        // Reset values
        #2;
        chk("rst_req", {31'd0, dmem_req_o}, 32'd0);
        chk("rst_stall", {31'd0, mem_stall_o}, 32'd0);
        chk("rst_wb_rw", {31'd0, wb_reg_write_o}, 32'd0);
        chk("rst_wb_alu", wb_alu_result_o, 32'd0);
        chk("rst_busy", {31'd0, dbg_state}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // ADD x5 = 0x55, ready high in IDLE must be ignored
        run_op(3'b000, 0, 0, 32'h55, 32'h0, 5'd5, 32'h1004, 1, 2'b00, 0, 32'h0, 1'b1,
               sc, rc, ba, bb, bw);
        chk("add_wb_alu", wb_alu_result_o, 32'h55);
        chk("add_wb_rd", {27'd0, wb_rd_addr_o}, 32'd5);
        chk("add_stall_cycles", sc, 0);
        chk("add_no_req", rc, 0);

        // LW 0x100, ready on first BUSY cycle
        run_op(3'b010, 1, 0, 32'h100, 32'h0, 5'd10, 32'h1008, 1, 2'b01, 0, 32'hDEADBEEF, 1'b0,
               sc, rc, ba, bb, bw);
        chk("lw_stall_cycles", sc, 1);
        chk("lw_wb_rdata", wb_mem_rdata_o, 32'hDEADBEEF);
        chk("lw_wb_rw", {31'd0, wb_reg_write_o}, 32'd1);

        // LB / LBU at 0x103
        run_op(3'b000, 1, 0, 32'h103, 32'h0, 5'd11, 32'h100C, 1, 2'b01, 0, 32'h80112233, 1'b0,
               sc, rc, ba, bb, bw);
        chk("lb_wb_rdata", wb_mem_rdata_o, 32'hFFFFFF80);
        run_op(3'b100, 1, 0, 32'h103, 32'h0, 5'd12, 32'h1010, 1, 2'b01, 1, 32'h80112233, 1'b0,
               sc, rc, ba, bb, bw);
        chk("lbu_wb_rdata", wb_mem_rdata_o, 32'h00000080);

        // SH 0x202, ready delayed three cycles
        run_op(3'b001, 0, 1, 32'h202, 32'h0000ABCD, 5'd0, 32'h1014, 0, 2'b00, 3, 32'h0, 1'b0,
               sc, rc, ba, bb, bw);
        chk("sh_be", {28'd0, bb}, 32'hC);
        chk("sh_wdata", bw, 32'hABCDABCD);
        chk("sh_addr", ba, 32'h200);
        chk("sh_stall_cycles", sc, 4);
        chk("sh_req_cycles", rc, 4);

        // Misaligned LW 0x101
        run_op(3'b010, 1, 0, 32'h101, 32'h0, 5'd13, 32'h1018, 1, 2'b01, 0, 32'h0, 1'b0,
               sc, rc, ba, bb, bw);
        chk("mis_flag", {31'd0, wb_misaligned_o}, 32'd1);
        chk("mis_wb_rw", {31'd0, wb_reg_write_o}, 32'd0);
        chk("mis_no_req", rc, 0);
        chk("mis_no_stall", sc, 0);

        // Further lanes and encodings
        run_op(3'b001, 1, 0, 32'h102, 32'h0, 5'd14, 32'h101C, 1, 2'b01, 2, 32'h80011234, 1'b0,
               sc, rc, ba, bb, bw);
        chk("lh_wb_rdata", wb_mem_rdata_o, 32'hFFFF8001);
        run_op(3'b101, 1, 0, 32'h100, 32'h0, 5'd15, 32'h1020, 1, 2'b01, 0, 32'h1234ABCD, 1'b0,
               sc, rc, ba, bb, bw);
        chk("lhu_wb_rdata", wb_mem_rdata_o, 32'h0000ABCD);
        // read and write together behave as a store
        run_op(3'b000, 1, 1, 32'h101, 32'h12345677, 5'd0, 32'h1024, 0, 2'b00, 1, 32'h0, 1'b0,
               sc, rc, ba, bb, bw);
        chk("sb_be", {28'd0, bb}, 32'h2);
        chk("sb_wdata", bw, 32'h77777777);
        run_op(3'b010, 0, 1, 32'h104, 32'hCAFEF00D, 5'd0, 32'h1028, 0, 2'b00, 0, 32'h0, 1'b0,
               sc, rc, ba, bb, bw);
        chk("sw_be", {28'd0, bb}, 32'hF);
        run_op(3'b011, 1, 0, 32'h108, 32'h0, 5'd16, 32'h102C, 1, 2'b01, 0, 32'h01020304, 1'b0,
               sc, rc, ba, bb, bw);
        chk("rsv011_wb_rdata", wb_mem_rdata_o, 32'h01020304);
        run_op(3'b110, 1, 0, 32'h10C, 32'h0, 5'd17, 32'h1030, 1, 2'b01, 2, 32'hA5A55A5A, 1'b0,
               sc, rc, ba, bb, bw);
        run_op(3'b001, 0, 1, 32'h203, 32'h1111, 5'd0, 32'h1034, 0, 2'b00, 0, 32'h0, 1'b0,
               sc, rc, ba, bb, bw);
        chk("mis_sh_flag", {31'd0, wb_misaligned_o}, 32'd1);
        run_op(3'b000, 0, 0, 32'h77, 32'h0, 5'd7, 32'h1038, 1, 2'b10, 0, 32'h0, 1'b0,
               sc, rc, ba, bb, bw);

        // Reset while BUSY abandons the access
        mem_alu_result_i = 32'h300; mem_funct3_i = 3'b010; mem_mem_read_i = 1'b1;
        mem_mem_write_i = 1'b0; mem_reg_write_i = 1'b1; mem_rd_addr_i = 5'd20;
        mem_mem_to_reg_i = 2'b01; mem_pc_plus_4_i = 32'h2000;
        rec = cur; rec.stall = 1'b1; exp_q.push_back(rec);
        @(posedge clk); #1;
        chk("abort_req_before", {31'd0, dmem_req_o}, 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_req_drop", {31'd0, dmem_req_o}, 32'd0);
        chk("abort_busy_clear", {31'd0, dbg_state}, 32'd0);
        chk("abort_stall", {31'd0, mem_stall_o}, 32'd0);
        mem_alu_result_i = '0; mem_funct3_i = '0; mem_mem_read_i = 1'b0;
        mem_reg_write_i = 1'b0; mem_rd_addr_i = '0; mem_mem_to_reg_i = '0;
        mem_pc_plus_4_i = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        dmem_ready_i = 1'b1; dmem_rdata_i = 32'h12345678;
        @(posedge clk); #1;
        dmem_ready_i = 1'b0;
        chk("abort_idle", {31'd0, dbg_state}, 32'd0);
        chk("abort_no_req", {31'd0, dmem_req_o}, 32'd0);
        chk("abort_no_rw", {31'd0, wb_reg_write_o}, 32'd0);
        cur = '0;

        run_op(3'b010, 1, 0, 32'h40, 32'h0, 5'd21, 32'h2004, 1, 2'b01, 1, 32'h0BADF00D, 1'b0,
               sc, rc, ba, bb, bw);
        chk("post_rst_lw", wb_mem_rdata_o, 32'h0BADF00D);
        run_op(3'b000, 0, 0, 32'h0, 32'h0, 5'd0, 32'h0, 0, 2'b00, 0, 32'h0, 1'b0,
               sc, rc, ba, bb, bw);

        @(posedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
